// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and types for the RV32 integer register file
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage : riscv_pkg

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending bits with issue/write-back tracking (REGFILE_BYPASS_EN)
module reg_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREG = riscv_pkg::NREG,
    parameter int AW   = riscv_pkg::REG_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_rd,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs1_pend,
    output logic          rs2_pend
);

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;

    // Next pending vector: write-back clears first, issue sets after so a
    // same-cycle issue to the same register supersedes the older producer.
    always_comb begin
        pending_d = pending_q;
        if (wb_en && (wb_addr != AW'(REG_ZERO))) begin
            pending_d[wb_addr] = 1'b0;
        end
        if (iss_en && (iss_rd != AW'(REG_ZERO))) begin
            pending_d[iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // Pending bit storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Effective pending lookups seen by the hazard check; issue this cycle
    // is deliberately not visible here.
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        rs1_pend = pending_q[rs1_addr] && !(wb_en && (wb_addr == rs1_addr));
        rs2_pend = pending_q[rs2_addr] && !(wb_en && (wb_addr == rs2_addr));
`else
        rs1_pend = pending_q[rs1_addr];
        rs2_pend = pending_q[rs2_addr];
`endif
    end

endmodule : reg_scoreboard

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, two registered read ports, one write port, pending scoreboard (REGFILE_BYPASS_EN)
module reg_file
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int NREG = riscv_pkg::NREG,
    parameter int AW   = riscv_pkg::REG_AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_req,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rd_valid,
    output logic            stall,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic            valid_q, valid_d;
    logic            rs1_pend, rs2_pend;
    logic            rd_accept;

    reg_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend)
    );

    // Hazard: refuse the read if either source still has a producer in flight.
    always_comb begin
        stall     = rd_req && (rs1_pend || rs2_pend);
        rd_accept = rd_req && !stall;
    end

    // Read-data next state: load both ports on acceptance, otherwise hold.
    always_comb begin
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        valid_d = 1'b0;
        if (rd_accept) begin
            valid_d = 1'b1;
            rs1_d   = mem_q[rs1_addr];
            rs2_d   = mem_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
            if (wb_en && (wb_addr == rs1_addr)) begin
                rs1_d = wb_data;
            end
            if (wb_en && (wb_addr == rs2_addr)) begin
                rs2_d = wb_data;
            end
`endif
            if (rs1_addr == AW'(REG_ZERO)) begin
                rs1_d = '0;
            end
            if (rs2_addr == AW'(REG_ZERO)) begin
                rs2_d = '0;
            end
        end
    end

    // Architectural storage; x0 is never written so it stays 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wb_en && (wb_addr != AW'(REG_ZERO))) begin
            mem_q[wb_addr] <= wb_data;
        end
    end

    // Registered read outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q   <= '0;
            rs2_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            valid_q <= valid_d;
        end
    end

    assign rs1_data = rs1_q;
    assign rs2_data = rs2_q;
    assign rd_valid = valid_q;

endmodule : reg_file
